gcd_engine: RTL and testbench



---
 rtl/gcd_engine.sv | 162 ++++++++++++++++
 tb/tb_gcd_engine.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_engine.sv
// Handshaked binary (Stein) GCD engine, one reduction step per clock.
// Optional RUN-cycle counter on _cycles when GCD_CYCLE_COUNT_EN is defined.
module gcd_engine #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             _clock,
    input  logic             _reset,
    input  logic             _start,
    input  logic [WIDTH-1:0] _num0,
    input  logic [WIDTH-1:0] _num1,
    output logic             _busy,
    output logic             _done,
    output logic [WIDTH-1:0] _greatest,
    output logic             _success
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [CNTW-1:0]  _cycles
`endif
);

    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    if (WIDTH < 2 || CNTW < 1) begin : g_param_check
        $error("gcd_engine: WIDTH must be >= 2 and CNTW >= 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] greatest_q, greatest_d;
    logic             success_q, success_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef GCD_CYCLE_COUNT_EN
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CNTW-1:0]  cycles_q, cycles_d;
    logic [CNTW-1:0]  cnt_inc;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNTW'(1);
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        k_d        = k_q;
        greatest_d = greatest_q;
        success_d  = success_q;
`ifdef GCD_CYCLE_COUNT_EN
        cnt_d      = cnt_q;
        cycles_d   = cycles_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (_start) begin
                    if (_num0 != '0 && _num1 != '0) begin
                        a_d       = _num0;
                        b_d       = _num1;
                        k_d       = '0;
                        success_d = 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
                        cnt_d     = '0;
`endif
                        state_d   = S_RUN;
                    end else begin
                        // gcd(x,0) = x, so the OR of the operands is the answer.
                        greatest_d = _num0 | _num1;
                        success_d  = ((_num0 | _num1) != '0);
`ifdef GCD_CYCLE_COUNT_EN
                        cycles_d   = '0;
`endif
                        state_d    = S_DONE;
                    end
                end
            end

            S_RUN: begin
`ifdef GCD_CYCLE_COUNT_EN
                cnt_d = cnt_inc;
`endif
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + KW'(1);
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q == b_q) begin
                    greatest_d = a_q << k_q;
                    success_d  = 1'b1;
`ifdef GCD_CYCLE_COUNT_EN
                    cycles_d   = cnt_inc;
`endif
                    state_d    = S_DONE;
                end else if (a_q > b_q) begin
                    // Both odd here: the difference is even, so the shift is exact.
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end

            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            greatest_q <= '0;
            success_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef GCD_CYCLE_COUNT_EN
            cnt_q      <= '0;
            cycles_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            k_q        <= k_d;
            greatest_q <= greatest_d;
            success_q  <= success_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef GCD_CYCLE_COUNT_EN
            cnt_q      <= cnt_d;
            cycles_q   <= cycles_d;
`endif
        end
    end

    assign _busy     = busy_q;
    assign _done     = done_q;
    assign _greatest = greatest_q;
    assign _success  = success_q;
`ifdef GCD_CYCLE_COUNT_EN
    assign _cycles   = cycles_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed WIDTH=8 scenarios and a WIDTH=16 random
// sweep, scored against a Euclid reference through an expected-result queue.
module tb_gcd_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  n0_8, n1_8;
    logic [15:0] n0_16, n1_16;
    logic        busy8, done8, succ8;
    logic [7:0]  g8;
    logic        busy16, done16, succ16;
    logic [15:0] g16;
`ifdef GCD_CYCLE_COUNT_EN
    logic [7:0]  cyc8, cyc16;
`endif

    always #5 clk = ~clk;

    gcd_engine #(.WIDTH(8), .CNTW(8)) dut8 (
        ._clock(clk), ._reset(rst), ._start(start8), ._num0(n0_8), ._num1(n1_8),
        ._busy(busy8), ._done(done8), ._greatest(g8), ._success(succ8)
`ifdef GCD_CYCLE_COUNT_EN
        , ._cycles(cyc8)
`endif
    );

    gcd_engine #(.WIDTH(16), .CNTW(8)) dut16 (
        ._clock(clk), ._reset(rst), ._start(start16), ._num0(n0_16), ._num1(n1_16),
        ._busy(busy16), ._done(done16), ._greatest(g16), ._success(succ16)
`ifdef GCD_CYCLE_COUNT_EN
        , ._cycles(cyc16)
`endif
    );

    typedef struct {
        logic [15:0] g;
        logic        s;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] last_g[2];
    bit          last_v[2];

    function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    function automatic logic [15:0] cur_g(input int sel);
        return (sel != 0) ? g16 : {8'h00, g8};
    endfunction

    function automatic logic cur_done(input int sel);
        return (sel != 0) ? done16 : done8;
    endfunction

    function automatic logic cur_busy(input int sel);
        return (sel != 0) ? busy16 : busy8;
    endfunction

    function automatic logic cur_succ(input int sel);
        return (sel != 0) ? succ16 : succ8;
    endfunction

`ifdef GCD_CYCLE_COUNT_EN
    function automatic int cur_cyc(input int sel);
        return (sel != 0) ? int'(cyc16) : int'(cyc8);
    endfunction
`endif

    task automatic drive(input int sel, input logic s, input logic [15:0] a, input logic [15:0] b);
        if (sel != 0) begin
            start16 = s; n0_16 = a; n1_16 = b;
        end else begin
            start8 = s; n0_8 = a[7:0]; n1_8 = b[7:0];
        end
    endtask

    // Latency is counted in clock edges after the accepting edge; 0 means _done is
    // already high in the cycle right after acceptance (zero-operand path).
    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input int exp_lat, input bit inject, output int lat);
        exp_t e, got;
        bit   zero;
        int   width, limit;
        width = (sel != 0) ? 16 : 8;
        limit = 2 * width + 4;
        zero  = (a == 0) || (b == 0);

        if (last_v[sel]) begin
            checks++;
            if (cur_g(sel) !== last_g[sel]) begin
                failures++;
                $display("FAIL hold_greatest sel=%0d got=%0d want=%0d", sel, cur_g(sel), last_g[sel]);
            end
        end

        @(negedge clk);
        drive(sel, 1'b1, a, b);
        e.g   = ref_gcd(a, b);
        e.s   = (e.g != 0);
        e.lat = exp_lat;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        if (inject) drive(sel, 1'b1, 16'd4, 16'd6);
        else        drive(sel, 1'b0, a, b);

        while (!cur_done(sel) && lat < limit) begin
            checks++;
            if (cur_busy(sel) !== !zero) begin
                failures++;
                $display("FAIL busy_in_run a=%0d b=%0d lat=%0d got=%b want=%b", a, b, lat, cur_busy(sel), !zero);
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
            drive(sel, 1'b0, a, b);
        end

        checks++;
        if (!cur_done(sel)) begin
            failures++;
            $display("FAIL done_timeout a=%0d b=%0d got=no_done want=done within %0d edges", a, b, limit);
            sb_q.delete();
            return;
        end

        got = sb_q.pop_front();
        checks++;
        if (cur_g(sel) !== got.g) begin
            failures++;
            $display("FAIL greatest a=%0d b=%0d got=%0d want=%0d", a, b, cur_g(sel), got.g);
        end
        checks++;
        if (cur_succ(sel) !== got.s) begin
            failures++;
            $display("FAIL success a=%0d b=%0d got=%b want=%b", a, b, cur_succ(sel), got.s);
        end
        checks++;
        if (cur_busy(sel) !== 1'b0) begin
            failures++;
            $display("FAIL busy_in_done a=%0d b=%0d got=%b want=0", a, b, cur_busy(sel));
        end
        checks++;
        if (got.lat >= 0) begin
            if (lat != got.lat) begin
                failures++;
                $display("FAIL latency a=%0d b=%0d got=%0d want=%0d", a, b, lat, got.lat);
            end
        end else if (lat < 1 || lat > 2 * width + 1) begin
            failures++;
            $display("FAIL latency_bound a=%0d b=%0d got=%0d want=1..%0d", a, b, lat, 2 * width + 1);
        end
`ifdef GCD_CYCLE_COUNT_EN
        checks++;
        if (cur_cyc(sel) != (zero ? 0 : lat)) begin
            failures++;
            $display("FAIL cycles a=%0d b=%0d got=%0d want=%0d", a, b, cur_cyc(sel), zero ? 0 : lat);
        end
`endif

        @(negedge clk);
        checks++;
        if (cur_done(sel) !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle a=%0d b=%0d got=%b want=0", a, b, cur_done(sel));
        end
        last_g[sel] = got.g;
        last_v[sel] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 16'd0, 16'd0);
        drive(1, 1'b0, 16'd0, 16'd0);
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, g8, succ8, busy16, done16, g16, succ16} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%h%b_%b%b%h%b want=all_zero",
                     busy8, done8, g8, succ8, busy16, done16, g16, succ16);
        end
`ifdef GCD_CYCLE_COUNT_EN
        checks++;
        if ({cyc8, cyc16} !== '0) begin
            failures++;
            $display("FAIL reset_cycles got=%0d/%0d want=0/0", cyc8, cyc16);
        end
`endif
        rst = 1'b0;
        last_g[0] = '0; last_g[1] = '0;
        last_v[0] = 1'b1; last_v[1] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int lat;
        run_op(0, 16'd48, 16'd18, 6, 1'b0, lat);
        run_op(0, 16'd17, 16'd13, 6, 1'b0, lat);
        run_op(0, 16'd0, 16'd25, 0, 1'b0, lat);
        run_op(0, 16'd0, 16'd0, 0, 1'b0, lat);
        run_op(0, 16'd36, 16'd0, 0, 1'b0, lat);
    endtask

    task automatic test_ignore_start();
        int lat;
        int extra;
        run_op(0, 16'd255, 16'd255, 1, 1'b1, lat);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL ignored_start got=%0d extra done pulses want=0", extra);
        end
        checks++;
        if (g8 !== 8'd255) begin
            failures++;
            $display("FAIL ignored_start_result got=%0d want=255", g8);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int extra;
        @(negedge clk);
        drive(0, 1'b1, 16'd48, 16'd18);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 16'd48, 16'd18);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_busy got=%b want=1", busy8);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, g8, succ8} !== '0) begin
            failures++;
            $display("FAIL async_reset got=busy%b done%b g%0d s%b want=all_zero", busy8, done8, g8, succ8);
        end
        @(negedge clk);
        rst = 1'b0;
        last_g[0] = '0; last_g[1] = '0;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL aborted_done got=%0d pulses want=0", extra);
        end
        run_op(0, 16'd12, 16'd8, 5, 1'b0, lat);
    endtask

    task automatic test_random_sweep();
        int          lat;
        logic [15:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            if (i % 3 == 0) b = 16'($urandom_range(1, 255));
            if (i % 50 == 7) a = 16'd0;
            if (i % 64 == 9) a = b;
            if (i % 40 == 5) begin
                a = 16'hc000;
                b = 16'h8000;
            end
            run_op(1, a, b, ((a == 0) || (b == 0)) ? 0 : -1, 1'b0, lat);
        end
    endtask

    initial begin
        last_v[0] = 1'b0;
        last_v[1] = 1'b0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
